// File: rtl/obufds_ldt_tx.sv
// LDT link transmitter: sends a training sequence after reset, then serializes
// handshaked words MSB-first onto complementary data and control pairs.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_TRAIN | training pattern on the line; counters point at the next bit
// S_IDLE  | no word pending, line idles at O=0 / CTL_O=1
// S_SHIFT | shifting a captured word; r_bit_cnt is the bit now on O
module obufds_ldt_tx #(
   parameter int               WIDTH         = 8,
   parameter int               TRAIN_WORDS   = 4,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'hA5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DIN,
   input  logic             CTL_IN,
   input  logic             DIN_VALID,
   output logic             DIN_READY,
   output logic             O,
   output logic             OB,
   output logic             CTL_O,
   output logic             CTL_OB,
   output logic             TRAINING
);

   localparam int             CW        = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [7:0]     TRAIN_END = 8'(TRAIN_WORDS);

   typedef enum logic [1:0] {S_TRAIN, S_IDLE, S_SHIFT} state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]       r_word_cnt, w_word_cnt_nxt;
   logic [WIDTH-1:0] r_sr, w_sr_nxt;
   logic             r_o, r_ob, r_ctl, r_ctlb, r_training;
   logic             w_o_nxt, w_ctl_nxt, w_ready, w_accept;
   logic [CW-1:0]    w_train_idx;
   logic             w_train_bit;

   assign w_train_idx = LAST_BIT - r_bit_cnt;
   assign w_train_bit = TRAIN_PATTERN[w_train_idx];

   // In TRAIN the counters have already wrapped past the final bit once it is on O.
   assign w_ready  = (r_state == S_IDLE)
                   | ((r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT))
                   | ((r_state == S_TRAIN) && (r_word_cnt == TRAIN_END));
   assign w_accept = w_ready & DIN_VALID;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_TRAIN;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_word_cnt_nxt = r_word_cnt;
      w_sr_nxt       = r_sr;
      w_o_nxt        = r_o;
      w_ctl_nxt      = r_ctl;
      if (w_ready) begin
         w_bit_cnt_nxt  = '0;
         w_word_cnt_nxt = '0;
         if (w_accept) begin
            w_state_nxt = S_SHIFT;
            w_o_nxt     = DIN[WIDTH-1];
            w_ctl_nxt   = CTL_IN;
            w_sr_nxt    = {DIN[WIDTH-2:0], 1'b0};
         end else begin
            w_state_nxt = S_IDLE;
            w_o_nxt     = 1'b0;
            w_ctl_nxt   = 1'b1;
         end
      end else if (r_state == S_TRAIN) begin
         w_o_nxt   = w_train_bit;
         w_ctl_nxt = 1'b0;
         if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_nxt  = '0;
            w_word_cnt_nxt = r_word_cnt + 8'd1;
         end else begin
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
         end
      end else begin
         w_o_nxt       = r_sr[WIDTH-1];
         w_sr_nxt      = {r_sr[WIDTH-2:0], 1'b0};
         w_bit_cnt_nxt = r_bit_cnt + CW'(1);
      end
   end

   // Each side of a pair has its own flop so the pair is complementary even in reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_sr       <= '0;
         r_o        <= 1'b0;
         r_ob       <= 1'b1;
         r_ctl      <= 1'b0;
         r_ctlb     <= 1'b1;
         r_training <= 1'b1;
      end else begin
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_word_cnt <= w_word_cnt_nxt;
         r_sr       <= w_sr_nxt;
         r_o        <= w_o_nxt;
         r_ob       <= ~w_o_nxt;
         r_ctl      <= w_ctl_nxt;
         r_ctlb     <= ~w_ctl_nxt;
         r_training <= (w_state_nxt == S_TRAIN);
      end
   end

   assign DIN_READY = w_ready;
   assign O         = r_o;
   assign OB        = r_ob;
   assign CTL_O     = r_ctl;
   assign CTL_OB    = r_ctlb;
   assign TRAINING  = r_training;

endmodule

// File: tb/tb_obufds_ldt_tx.sv
// Directed bench for obufds_ldt_tx: training, single/back-to-back words,
// end-of-training transfer, input stability and asynchronous mid-word reset.
module tb_obufds_ldt_tx;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] DIN;
   logic       CTL_IN;
   logic       DIN_VALID;
   logic       DIN_READY, O, OB, CTL_O, CTL_OB, TRAINING;

   int n_chk = 0;
   int n_err = 0;

   obufds_ldt_tx #(.WIDTH(8), .TRAIN_WORDS(4), .TRAIN_PATTERN(8'hA5)) dut (
      .CLK(CLK), .RST(RST), .DIN(DIN), .CTL_IN(CTL_IN), .DIN_VALID(DIN_VALID),
      .DIN_READY(DIN_READY), .O(O), .OB(OB), .CTL_O(CTL_O), .CTL_OB(CTL_OB),
      .TRAINING(TRAINING)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Line state for one serial bit: data, control and the complements.
   task automatic chk_line(input string tag, input logic eo, input logic ectl);
      logic nb, nc;
      nb = !eo;
      nc = !ectl;
      chk({tag, "_o"},   O,      eo);
      chk({tag, "_ob"},  OB,     nb);
      chk({tag, "_ctl"}, CTL_O,  ectl);
      chk({tag, "_ctb"}, CTL_OB, nc);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_line(tag, 1'b0, 1'b0);
      chk({tag, "_rdy"}, DIN_READY, 1'b0);
      chk({tag, "_trn"}, TRAINING,  1'b1);
   endtask

   // Cycles 1..32 of training, then cycle 33 either idle or first word bit.
   task automatic train_check(input bit with_word);
      logic [7:0] pat;
      logic       b, r;
      pat = 8'hA5;
      for (int c = 1; c <= 32; c++) begin
         @(negedge CLK);
         b = pat[7 - ((c - 1) % 8)];
         r = (c == 32);
         chk_line("trn", b, 1'b0);
         chk("trn_training", TRAINING, 1'b1);
         chk("trn_rdy", DIN_READY, r);
      end
      @(negedge CLK);
      chk("c33_training", TRAINING, 1'b0);
      if (with_word) begin
         chk_line("c33_word", 1'b1, 1'b0);
         chk("c33_rdy", DIN_READY, 1'b0);
      end else begin
         chk_line("c33_idle", 1'b0, 1'b1);
         chk("c33_rdy", DIN_READY, 1'b1);
      end
   endtask

   initial begin
      logic [7:0]  w;
      logic [15:0] s;
      logic        r;
      RST = 1'b1; DIN = 8'h00; CTL_IN = 1'b0; DIN_VALID = 1'b0;
      repeat (2) @(negedge CLK);
      chk_reset_vals("rst");
      RST = 1'b0;

      train_check(1'b0);

      // single word from idle
      DIN = 8'h3C; CTL_IN = 1'b0; DIN_VALID = 1'b1;
      w = 8'h3C;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (k == 0) DIN_VALID = 1'b0;
         r = (k == 7);
         chk_line("one", w[7-k], 1'b0);
         chk("one_rdy", DIN_READY, r);
      end
      @(negedge CLK);
      chk_line("one_idle", 1'b0, 1'b1);
      chk("one_idle_rdy", DIN_READY, 1'b1);

      // back-to-back: FF (ctl) then 01 (data)
      DIN = 8'hFF; CTL_IN = 1'b1; DIN_VALID = 1'b1;
      s = 16'hFF01;
      for (int k = 0; k < 16; k++) begin
         @(negedge CLK);
         if (k == 0) begin DIN = 8'h01; CTL_IN = 1'b0; end
         if (k == 8) DIN_VALID = 1'b0;
         chk_line("b2b", s[15-k], (k < 8));
      end
      @(negedge CLK);
      chk_line("b2b_idle", 1'b0, 1'b1);

      // input stability: DIN scrambled after acceptance of AA
      DIN = 8'hAA; CTL_IN = 1'b0; DIN_VALID = 1'b1;
      w = 8'hAA;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (k == 0) DIN_VALID = 1'b0;
         chk_line("stab", w[7-k], 1'b0);
         DIN = 8'($urandom);
         CTL_IN = 1'($urandom);
      end
      @(negedge CLK);
      chk_line("stab_idle", 1'b0, 1'b1);

      // asynchronous reset while bit 4 of 5A is on the line
      DIN = 8'h5A; CTL_IN = 1'b1; DIN_VALID = 1'b1;
      w = 8'h5A;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         if (k == 0) DIN_VALID = 1'b0;
         chk_line("mid", w[7-k], 1'b1);
      end
      #2 RST = 1'b1;
      #1 chk_reset_vals("async_rst");
      DIN = 8'h80; CTL_IN = 1'b0; DIN_VALID = 1'b1;
      @(negedge CLK);
      chk_reset_vals("rst_hold");
      RST = 1'b0;

      // full training again, with 80 offered the whole time
      train_check(1'b1);
      DIN_VALID = 1'b0;
      for (int k = 1; k < 8; k++) begin
         @(negedge CLK);
         r = (k == 7);
         chk_line("end_trn", 1'b0, 1'b0);
         chk("end_trn_rdy", DIN_READY, r);
      end
      @(negedge CLK);
      chk_line("end_idle", 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
